// File: rtl/multi_button_debouncer.sv
// N-channel pushbutton front end: synchroniser, debouncer, edge pulses, toggle register
// and long-press/auto-repeat detection. The release pulse port is release_pulse because release is a reserved word.
module multi_button_debouncer #(
  parameter int               N_CH            = 4,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter int               HOLD_CYCLES     = 50000000,
  parameter int               REPEAT_CYCLES   = 12500000,
  parameter bit               TOGGLE_ON_PRESS = 1'b0,
  parameter bit               LONG_SUPPRESS   = 1'b1,
  parameter logic [N_CH-1:0]  INIT_ENABLE     = {N_CH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  button,
  input  logic [N_CH-1:0]  load,
  input  logic [N_CH-1:0]  load_val,
  output logic [N_CH-1:0]  state,
  output logic [N_CH-1:0]  press,
  output logic [N_CH-1:0]  release_pulse,
  output logic [N_CH-1:0]  long_press,
  output logic [N_CH-1:0]  repeat_pulse,
  output logic [N_CH-1:0]  enable
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int RW = (REPEAT_CYCLES > 0) ? $clog2(REPEAT_CYCLES + 1) : 1;

  localparam logic [DW-1:0] D_LIM = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] H_LIM = HW'(HOLD_CYCLES);
  localparam logic [RW-1:0] R_LIM = RW'(REPEAT_CYCLES);
  localparam logic [RW-1:0] R_ONE = RW'(1);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic          s1, s2, st, st_d;
    logic [DW-1:0] dcnt;
    logic [HW-1:0] hcnt;
    logic [RW-1:0] rcnt;
    logic          long_fired;
    logic          pr, rl, lp, rp, en;
    logic          rise, fall, tog;

    assign rise = st & ~st_d;
    assign fall = ~st & st_d;
    // In release-toggle mode a release that ends a long press can be suppressed.
    assign tog  = TOGGLE_ON_PRESS ? rise
                                  : (fall & ~(LONG_SUPPRESS & long_fired));

    always_ff @(posedge clk) begin
      if (rst) begin
        s1         <= 1'b0;
        s2         <= 1'b0;
        st         <= 1'b0;
        st_d       <= 1'b0;
        dcnt       <= '0;
        hcnt       <= '0;
        rcnt       <= '0;
        long_fired <= 1'b0;
        pr         <= 1'b0;
        rl         <= 1'b0;
        lp         <= 1'b0;
        rp         <= 1'b0;
        en         <= INIT_ENABLE[i];
      end else begin
        s1 <= button[i];
        s2 <= s1;

        if (s2 == st) begin
          dcnt <= '0;
        end else if (dcnt == D_LIM) begin
          st   <= s2;
          dcnt <= '0;
        end else begin
          dcnt <= dcnt + 1'b1;
        end

        st_d <= st;
        pr   <= rise;
        rl   <= fall;
        lp   <= 1'b0;
        rp   <= 1'b0;

        if (!st) begin
          hcnt       <= '0;
          rcnt       <= '0;
          long_fired <= 1'b0;
        end else begin
          if (hcnt != '1)
            hcnt <= hcnt + 1'b1;
          if (!long_fired && hcnt == H_LIM) begin
            lp         <= 1'b1;
            long_fired <= 1'b1;
            rcnt       <= R_ONE;
          end else if (long_fired && REPEAT_CYCLES > 0) begin
            // rcnt counts 1..REPEAT_CYCLES so the k-th repeat lands k periods after long_press
            if (rcnt == R_LIM) begin
              rp   <= 1'b1;
              rcnt <= R_ONE;
            end else begin
              rcnt <= rcnt + 1'b1;
            end
          end
        end

        if (load[i])
          en <= load_val[i];
        else if (tog)
          en <= ~en;
      end
    end

    assign state[i]         = st;
    assign press[i]         = pr;
    assign release_pulse[i] = rl;
    assign long_press[i]    = lp;
    assign repeat_pulse[i]  = rp;
    assign enable[i]        = en;
  end

endmodule

// File: tb/tb_multi_button_debouncer.sv
// Directed bench for multi_button_debouncer: three instances cover release-toggle,
// long-press/repeat with suppression, and press-toggle with repeat disabled.
module tb_multi_button_debouncer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [1:0] btn_a = '0, ld_a = '0, lv_a = '0;
  logic [1:0] st_a, pr_a, rl_a, lp_a, rp_a, en_a;
  logic [1:0] btn_b = '0, ld_b = '0, lv_b = '0;
  logic [1:0] st_b, pr_b, rl_b, lp_b, rp_b, en_b;
  logic [1:0] btn_c = '0, ld_c = '0, lv_c = '0;
  logic [1:0] st_c, pr_c, rl_c, lp_c, rp_c, en_c;

  multi_button_debouncer #(.N_CH(2), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(1000), .REPEAT_CYCLES(3),
                           .TOGGLE_ON_PRESS(1'b0), .LONG_SUPPRESS(1'b1)) dut_a (
    .clk(clk), .rst(rst), .button(btn_a), .load(ld_a), .load_val(lv_a),
    .state(st_a), .press(pr_a), .release_pulse(rl_a), .long_press(lp_a),
    .repeat_pulse(rp_a), .enable(en_a));

  multi_button_debouncer #(.N_CH(2), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10), .REPEAT_CYCLES(3),
                           .TOGGLE_ON_PRESS(1'b0), .LONG_SUPPRESS(1'b1)) dut_b (
    .clk(clk), .rst(rst), .button(btn_b), .load(ld_b), .load_val(lv_b),
    .state(st_b), .press(pr_b), .release_pulse(rl_b), .long_press(lp_b),
    .repeat_pulse(rp_b), .enable(en_b));

  multi_button_debouncer #(.N_CH(2), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10), .REPEAT_CYCLES(0),
                           .TOGGLE_ON_PRESS(1'b1), .LONG_SUPPRESS(1'b1)) dut_c (
    .clk(clk), .rst(rst), .button(btn_c), .load(ld_c), .load_val(lv_c),
    .state(st_c), .press(pr_c), .release_pulse(rl_c), .long_press(lp_c),
    .repeat_pulse(rp_c), .enable(en_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({st_a, pr_a, rl_a, lp_a, rp_a} !== 10'b0) begin
      errors++; $display("FAIL reset_outputs got=%b exp=0", {st_a, pr_a, rl_a, lp_a, rp_a});
    end
    checks++;
    if (en_a !== 2'b11 || en_b !== 2'b11 || en_c !== 2'b11) begin
      errors++; $display("FAIL reset_enable got=%b/%b/%b exp=11", en_a, en_b, en_c);
    end
    rst = 1'b0;
  endtask

  task automatic test_latency();
    logic e_st, e_pr, e_rl, e_en;
    btn_a[0] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      e_st = (k >= 5); e_pr = (k == 6);
      checks++;
      if (st_a[0] !== e_st) begin errors++; $display("FAIL lat_state k=%0d got=%b exp=%b", k, st_a[0], e_st); end
      checks++;
      if (pr_a[0] !== e_pr) begin errors++; $display("FAIL lat_press k=%0d got=%b exp=%b", k, pr_a[0], e_pr); end
      checks++;
      if (en_a[0] !== 1'b1) begin errors++; $display("FAIL lat_enable_hold k=%0d got=%b exp=1", k, en_a[0]); end
    end
    btn_a[0] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      e_st = (k < 5); e_rl = (k == 6); e_en = (k < 6);
      checks++;
      if (st_a[0] !== e_st) begin errors++; $display("FAIL rel_state k=%0d got=%b exp=%b", k, st_a[0], e_st); end
      checks++;
      if (rl_a[0] !== e_rl) begin errors++; $display("FAIL rel_pulse k=%0d got=%b exp=%b", k, rl_a[0], e_rl); end
      checks++;
      if (en_a[0] !== e_en) begin errors++; $display("FAIL rel_enable k=%0d got=%b exp=%b", k, en_a[0], e_en); end
      checks++;
      if (pr_a[0] !== 1'b0) begin errors++; $display("FAIL rel_no_press k=%0d got=%b exp=0", k, pr_a[0]); end
    end
    checks++;
    if (st_a[1] !== 1'b0 || en_a[1] !== 1'b1) begin
      errors++; $display("FAIL lat_ch1_untouched got st=%b en=%b exp st=0 en=1", st_a[1], en_a[1]);
    end
  endtask

  task automatic test_glitch();
    logic pat [14] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1,
                       1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic e_st, e_pr, e_rl, e_en;
    for (int k = 0; k < 14; k++) begin
      btn_a[1] = pat[k];
      tick();
      checks++;
      if (st_a[1] !== 1'b0 || pr_a[1] !== 1'b0 || en_a[1] !== 1'b1) begin
        errors++; $display("FAIL glitch_reject k=%0d got st=%b pr=%b en=%b exp 0/0/1", k, st_a[1], pr_a[1], en_a[1]);
      end
    end
    for (int k = 0; k < 12; k++) begin
      btn_a[1] = (k < 4);
      tick();
      e_st = (k >= 5 && k <= 8); e_pr = (k == 6); e_rl = (k == 10); e_en = (k < 10);
      checks++;
      if (st_a[1] !== e_st) begin errors++; $display("FAIL accept_state k=%0d got=%b exp=%b", k, st_a[1], e_st); end
      checks++;
      if (pr_a[1] !== e_pr) begin errors++; $display("FAIL accept_press k=%0d got=%b exp=%b", k, pr_a[1], e_pr); end
      checks++;
      if (rl_a[1] !== e_rl) begin errors++; $display("FAIL accept_release k=%0d got=%b exp=%b", k, rl_a[1], e_rl); end
      checks++;
      if (en_a[1] !== e_en) begin errors++; $display("FAIL accept_enable k=%0d got=%b exp=%b", k, en_a[1], e_en); end
    end
  endtask

  task automatic test_load();
    lv_a[0] = 1'b1; ld_a[0] = 1'b1;
    tick();
    ld_a[0] = 1'b0;
    checks++;
    if (en_a !== 2'b01) begin errors++; $display("FAIL load_plain got=%b exp=01", en_a); end
    btn_a[0] = 1'b1;
    repeat (10) tick();
    btn_a[0] = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    ld_a[0] = 1'b1; lv_a[0] = 1'b1;
    tick();
    ld_a[0] = 1'b0;
    checks++;
    if (rl_a[0] !== 1'b1) begin errors++; $display("FAIL collide_release got=%b exp=1", rl_a[0]); end
    checks++;
    if (en_a[0] !== 1'b1) begin errors++; $display("FAIL collide_enable got=%b exp=1", en_a[0]); end
    tick();
    checks++;
    if (en_a[0] !== 1'b1) begin errors++; $display("FAIL collide_after got=%b exp=1", en_a[0]); end
    lv_a[0] = 1'b0; ld_a[0] = 1'b1;
    tick();
    ld_a[0] = 1'b0;
    checks++;
    if (en_a !== 2'b00) begin errors++; $display("FAIL load_zero got=%b exp=00", en_a); end
  endtask

  task automatic test_long_repeat();
    logic e_pr, e_lp, e_rp, e_rl;
    for (int k = 0; k < 46; k++) begin
      btn_b[0] = (k <= 26);
      tick();
      e_pr = (k == 6); e_lp = (k == 16); e_rl = (k == 33);
      e_rp = (k >= 19 && k <= 31 && ((k - 16) % 3 == 0));
      checks++;
      if (pr_b[0] !== e_pr) begin errors++; $display("FAIL long_press_pulse k=%0d got=%b exp=%b", k, pr_b[0], e_pr); end
      checks++;
      if (lp_b[0] !== e_lp) begin errors++; $display("FAIL long_long k=%0d got=%b exp=%b", k, lp_b[0], e_lp); end
      checks++;
      if (rp_b[0] !== e_rp) begin errors++; $display("FAIL long_repeat k=%0d got=%b exp=%b", k, rp_b[0], e_rp); end
      checks++;
      if (rl_b[0] !== e_rl) begin errors++; $display("FAIL long_release k=%0d got=%b exp=%b", k, rl_b[0], e_rl); end
      checks++;
      if (en_b[0] !== 1'b1) begin errors++; $display("FAIL long_suppress k=%0d got=%b exp=1", k, en_b[0]); end
    end
  endtask

  task automatic test_no_repeat_press_toggle();
    logic e_pr, e_lp, e_rl, e_en;
    for (int k = 0; k < 56; k++) begin
      btn_c[0] = (k <= 40);
      tick();
      e_pr = (k == 6); e_lp = (k == 16); e_rl = (k == 47); e_en = (k < 6);
      checks++;
      if (pr_c[0] !== e_pr) begin errors++; $display("FAIL norep_press k=%0d got=%b exp=%b", k, pr_c[0], e_pr); end
      checks++;
      if (lp_c[0] !== e_lp) begin errors++; $display("FAIL norep_long k=%0d got=%b exp=%b", k, lp_c[0], e_lp); end
      checks++;
      if (rp_c[0] !== 1'b0) begin errors++; $display("FAIL norep_repeat k=%0d got=%b exp=0", k, rp_c[0]); end
      checks++;
      if (rl_c[0] !== e_rl) begin errors++; $display("FAIL norep_release k=%0d got=%b exp=%b", k, rl_c[0], e_rl); end
      checks++;
      if (en_c[0] !== e_en) begin errors++; $display("FAIL norep_enable k=%0d got=%b exp=%b", k, en_c[0], e_en); end
    end
  endtask

  task automatic test_reset_mid();
    logic e_st, e_pr;
    btn_a[1] = 1'b1;
    repeat (8) tick();
    checks++;
    if (st_a[1] !== 1'b1) begin errors++; $display("FAIL rstmid_pre_state got=%b exp=1", st_a[1]); end
    btn_a[0] = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({st_a, pr_a, rl_a, lp_a, rp_a} !== 10'b0) begin
      errors++; $display("FAIL rstmid_outputs got=%b exp=0", {st_a, pr_a, rl_a, lp_a, rp_a});
    end
    checks++;
    if (en_a !== 2'b11) begin errors++; $display("FAIL rstmid_enable got=%b exp=11", en_a); end
    btn_a[0] = 1'b0;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 9; k++) begin
      tick();
      e_st = (k >= 5); e_pr = (k == 6);
      checks++;
      if (st_a[1] !== e_st) begin errors++; $display("FAIL rstmid_state k=%0d got=%b exp=%b", k, st_a[1], e_st); end
      checks++;
      if (pr_a[1] !== e_pr) begin errors++; $display("FAIL rstmid_press k=%0d got=%b exp=%b", k, pr_a[1], e_pr); end
      checks++;
      if (st_a[0] !== 1'b0) begin errors++; $display("FAIL rstmid_ch0 k=%0d got=%b exp=0", k, st_a[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_load();
    test_long_repeat();
    test_no_repeat_press_toggle();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
